// File: rtl/seq_adder_pkg.sv
// Shared state encoding and default timing constants for the past_sequence_adder
// sequencing controller.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEF_CLR_CYCLES   = 16;
    localparam int DEF_DRAIN_CYCLES = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_adder_cnt.sv
// Loadable up-counter with a terminal-count flag; used for the clear, sample and
// drain phases of the sequencing controller.
module seq_adder_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/seq_adder_ctrl.sv
// Sequencer for an external past_sequence_adder: purges its history with zeros,
// streams a handshaked burst through it, then drains the tail and tags valid sums.
module seq_adder_ctrl
    import seq_adder_pkg::*;
#(
    parameter int N            = 4,
    parameter int DW           = 8,
    parameter int LW           = 8,
    parameter int CLR_CYCLES   = DEF_CLR_CYCLES,
    parameter int DRAIN_CYCLES = (N > 0) ? N : DEF_DRAIN_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          stop,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] add_inp,
    input  logic [DW-1:0] add_outp,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(max2(CLR_CYCLES, DRAIN_CYCLES) + 1);

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] len_q;
    logic          done_q;
    logic          clr_tc;
    logic          smp_tc;
    logic          dr_tc;
    logic          hs;

    assign hs = in_valid & in_ready;

    // Each phase counter holds zero outside its own state, so entry always starts at 0.
    seq_adder_cnt #(.W(CW)) u_clr_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state != ST_CLEAR),
        .load_val ('0),
        .en       (state == ST_CLEAR),
        .last     (CW'(CLR_CYCLES - 1)),
        .tc       (clr_tc)
    );

    seq_adder_cnt #(.W(LW)) u_smp_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state != ST_RUN),
        .load_val ('0),
        .en       (hs),
        .last     (len_q - LW'(1)),
        .tc       (smp_tc)
    );

    seq_adder_cnt #(.W(CW)) u_dr_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state != ST_DRAIN),
        .load_val ('0),
        .en       (state == ST_DRAIN),
        .last     (CW'(DRAIN_CYCLES - 1)),
        .tc       (dr_tc)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        add_inp   = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_tc) state_nx = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    add_inp   = in_data;
                    out_valid = 1'b1;
                end
                if ((in_valid && smp_tc) || stop) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_last  = dr_tc;
                if (dr_tc) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // A reset cycle must never complete a handshake or present a result.
        if (rst) begin
            in_ready  = 1'b0;
            add_inp   = '0;
            out_valid = 1'b0;
            out_last  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state == ST_DRAIN) && dr_tc;
            if (state == ST_IDLE && start) begin
                len_q <= (len == '0) ? LW'(1) : len;
            end
        end
    end

    assign out_data = add_outp;
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// Directed bench for seq_adder_ctrl driving a behavioural N=4/DW=8 past-sequence
// adder: y = x + h0 + 2*h1 + 4*h2 + 8*h3 (h0 = most recent past input).
module tb_seq_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, in_valid, in_ready;
    logic [7:0] len, in_data, add_inp, add_outp, out_data;
    logic       out_valid, out_last, busy, done;
    logic       preload;
    logic [3:0][7:0] hist;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_adder_ctrl #(.N(4), .DW(8), .LW(8), .CLR_CYCLES(16), .DRAIN_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_inp   (add_inp),
        .add_outp  (add_outp),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        if (preload) hist <= {8'h5A, 8'hC3, 8'h7E, 8'h99};
        else         hist <= {hist[2:0], add_inp};
    end

    assign add_outp = 8'(add_inp + hist[0] + (hist[1] << 1) + (hist[2] << 2) + (hist[3] << 3));

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       ov;
        logic       last;
        logic       dn;
        logic [7:0] add;
        logic [7:0] out;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        #1;
        while (!in_ready && n < 200) begin
            n++;
            cyc();
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int dr_exp [4];
        dr_exp = '{15, 14, 12, 8};

        tbl[0] = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd3};
        tbl[1] = '{1'b0, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3};
        tbl[2] = '{1'b0, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd6};
        tbl[3] = '{1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 8'd17};
        tbl[4] = '{1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7, 8'd36};
        tbl[5] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd17};
        tbl[6] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd34};
        tbl[7] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd68};
        tbl[8] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd56};
        tbl[9] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0};

        rst = 1'b1; start = 1'b0; len = 8'd0; stop = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; preload = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset / idle
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_ready", in_ready, 0);
            chk("idle_ovalid", out_valid, 0);
            chk("idle_add_inp", add_inp, 0);
            chk("idle_done", done, 0);
            cyc();
        end

        // Purge then single sample, len=1 with garbage adder history
        start = 1'b1; len = 8'd1; preload = 1'b1;
        #1;
        chk("t2_start_busy", busy, 0);
        cyc();
        start = 1'b0; preload = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t2_clr_ready", in_ready, 0);
            chk("t2_clr_add_inp", add_inp, 0);
            chk("t2_clr_ovalid", out_valid, 0);
            chk("t2_clr_busy", busy, 1);
            cyc();
        end
        in_valid = 1'b1; in_data = 8'd1;
        #1;
        chk("t2_run_ready", in_ready, 1);
        chk("t2_run_ovalid", out_valid, 1);
        chk("t2_run_add_inp", add_inp, 1);
        chk("t2_run_out", out_data, 1);
        cyc();
        for (int d = 0; d < 4; d++) begin
            #1;
            chk("t2_dr_ready", in_ready, 0);
            chk("t2_dr_ovalid", out_valid, 1);
            chk("t2_dr_last", out_last, (d == 3) ? 1 : 0);
            chk("t2_dr_out", out_data, 1 << d);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("t2_done", done, 1);
        chk("t2_done_busy", busy, 0);
        chk("t2_done_ovalid", out_valid, 0);
        cyc();
        #1;
        chk("t2_done_once", done, 0);

        // Steady state, len=40, constant ones
        start = 1'b1; len = 8'd40;
        cyc();
        start = 1'b0;
        wait_ready(n);
        chk("t3_clr_cycles", n, 16);
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1; in_data = 8'd1;
            #1;
            chk("t3_run_ovalid", out_valid, 1);
            chk("t3_run_out", out_data, (k >= 4) ? 16 : (1 << k));
            cyc();
        end
        for (int d = 0; d < 4; d++) begin
            #1;
            chk("t3_dr_ready", in_ready, 0);
            chk("t3_dr_out", out_data, dr_exp[d]);
            chk("t3_dr_last", out_last, (d == 3) ? 1 : 0);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("t3_done", done, 1);
        cyc();

        // Bubbles, len=3, in_valid 1,0,0,1,1
        start = 1'b1; len = 8'd3;
        cyc();
        start = 1'b0;
        wait_ready(n);
        chk("t4_clr_cycles", n, 16);
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].d;
            #1;
            chk("t4_ready", in_ready, tbl[i].rdy);
            chk("t4_ovalid", out_valid, tbl[i].ov);
            chk("t4_last", out_last, tbl[i].last);
            chk("t4_done", done, tbl[i].dn);
            chk("t4_add_inp", add_inp, tbl[i].add);
            chk("t4_out", out_data, tbl[i].out);
            cyc();
        end
        in_valid = 1'b0;

        // Early stop on the 4th handshake; start during DRAIN ignored, start with done accepted
        start = 1'b1; len = 8'd10;
        cyc();
        start = 1'b0;
        wait_ready(n);
        chk("t5_clr_cycles", n, 16);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'd1; stop = (k == 3);
            #1;
            chk("t5_run_ready", in_ready, 1);
            chk("t5_run_ovalid", out_valid, 1);
            cyc();
        end
        stop = 1'b0; in_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin
            start = 1'b1; len = 8'd2;
            #1;
            chk("t5_dr_ready", in_ready, 0);
            chk("t5_dr_ovalid", out_valid, 1);
            chk("t5_dr_busy", busy, 1);
            chk("t5_dr_last", out_last, (d == 3) ? 1 : 0);
            cyc();
        end
        len = 8'd10;
        #1;
        chk("t5_done", done, 1);
        cyc();
        start = 1'b0;
        #1;
        chk("t5_restart_busy", busy, 1);
        wait_ready(n);
        chk("t5_restart_clr", n, 16);

        // Reset after two samples of the restarted burst
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 8'd2;
            #1;
            chk("t6_run_ovalid", out_valid, 1);
            cyc();
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", in_ready, 0);
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("t6_post_busy", busy, 0);
        chk("t6_post_done", done, 0);
        chk("t6_post_ovalid", out_valid, 0);
        cyc();
        #1;
        chk("t6_post_done2", done, 0);
        start = 1'b1; len = 8'd0;
        cyc();
        start = 1'b0;
        wait_ready(n);
        chk("t6_clr_cycles", n, 16);
        in_valid = 1'b1; in_data = 8'd4;
        #1;
        chk("t6_len0_out", out_data, 4);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("t6_len0_drain", in_ready, 0);
        repeat (4) cyc();
        #1;
        chk("t6_len0_done", done, 1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_adder_ctrl.md
Name: seq_adder_ctrl

Overview:
Sequencing controller for the past_sequence_adder datapath (N stages, DW bits). That datapath has a combinational output and shifts on every clk edge.
- Before each burst, the controller purges the datapath history by feeding zeros.
- It then streams a programmable-length burst of samples in through a valid/ready handshake.
- It drains the tail with zeros and tags which datapath outputs are valid.
- It sits between the upstream sample source and the free-running adder instance, which lives outside this block.

Parameters:
N, 4, stage count of the controlled adder (informational; sets DRAIN_CYCLES default)
DW, 8, sample/sum width
LW, 8, burst-length counter width
CLR_CYCLES, 16, zero-feed cycles in CLEAR; must be ≥ adder history depth
DRAIN_CYCLES, 4, zero-feed cycles in DRAIN after last sample

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  begin a burst; sampled only in IDLE
len  in  LW  burst length in samples; latched on accepted start; 0 treated as 1
stop  in  1  early burst termination request, honoured in RUN
in_valid  in  1  upstream sample valid
in_data  in  DW  upstream sample
in_ready  out  1  controller accepts sample this cycle
add_inp  out  DW  drive to adder inp
add_outp  in  DW  adder outp
out_valid  out  1  out_data is a real result
out_data  out  DW  = add_outp (pass-through)
out_last  out  1  final valid output of burst
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset, or rst asserted in any state: state=IDLE; all counters 0; in_ready, out_valid, out_last and done = 0; add_inp=0. An in-flight burst is abandoned and no done pulse is issued.
- Outputs are combinational from state/counters/inputs; all counters are registered.
- IDLE:
  - add_inp=0, in_ready=0.
  - start=1 → latch len (0→1), clr_cnt=0, go CLEAR.
- CLEAR:
  - add_inp=0, in_ready=0, out_valid=0.
  - Lasts exactly CLR_CYCLES cycles, then RUN with smp_cnt=0.
- RUN:
  - in_ready=1.
  - On handshake (in_valid&in_ready): add_inp=in_data; out_valid=1; out_data=add_outp (zero latency, since adder output is combinational in inp); smp_cnt++.
  - No handshake: add_inp=0 (idle cycle counts as a zero sample by definition); out_valid=0.
  - Handshake where smp_cnt+1==len_q, or stop=1 in any RUN cycle → next state DRAIN, dr_cnt=0.
  - stop together with a handshake: that sample is accepted and is the last sample.
- DRAIN:
  - add_inp=0, in_ready=0, out_valid=1 every cycle (tail outputs).
  - Lasts DRAIN_CYCLES cycles; out_last=1 on the final DRAIN cycle.
  - Then IDLE with done=1 for one cycle in IDLE.
- start outside IDLE is ignored. start in the same cycle as the done pulse is accepted (IDLE rules apply).
- Counters wrap-free:
  - clr_cnt/dr_cnt sized $clog2(max(CLR_CYCLES,DRAIN_CYCLES)+1).
  - smp_cnt is LW bits; len=2^LW-1 max burst.
- No arithmetic on data; DW pass-through only.

Decomposition:
- Package seq_adder_pkg holds:
  - State encoding localparams: ST_IDLE, ST_CLEAR, ST_RUN, ST_DRAIN (2-bit).
  - Default CLR_CYCLES/DRAIN_CYCLES constants.
- One natural sub-module: seq_adder_cnt, a loadable up-counter with terminal-count flag, instanced for clr, smp and drain.
- The adder itself is instanced by the parent, not inside this block.

Test Plan:
1. Reset/idle: rst high 3 cycles, then low with start=0 → busy=0, in_ready=0, out_valid=0, add_inp=0 indefinitely.
2. Purge then first sample:
   - Stimulus: start, len=1, in_valid=1, in_data=1, bench adder N=4/DW=8 preloaded with garbage.
   - Required: exactly 16 CLEAR cycles with add_inp=0, then out_data=1 on the handshake cycle, 4 DRAIN cycles, out_last on the 4th, done one cycle later.
3. Steady state: len=40, constant in_data=1, in_valid always 1 → out_data ramps and settles at 16 (1·2^4) well before sample 40. Exactly 40 handshakes, then DRAIN.
4. Bubbles: len=3, in_valid pattern 1,0,0,1,1 → in_ready high throughout RUN. out_valid only on the 3 handshake cycles. add_inp=0 on the bubble cycles. DRAIN entered after the 3rd handshake.
5. Early stop: len=10, stop asserted with the 4th handshake → 4 samples accepted, DRAIN begins next cycle, done after DRAIN. start during DRAIN is ignored; start asserted with done starts a new CLEAR.
6. Reset mid-RUN: rst after 2 samples → next cycle IDLE, no done pulse. A following start performs a full 16-cycle CLEAR.
